// File: rtl/mmu_pkg.sv
// Shared MMU definitions: MIPS32 segment constants, queue entry type and the
// fixed kseg0/kseg1/unmapped translation used by both I-side and D-side.
package mmu_pkg;

    localparam int MMU_ADDR_W    = 32;
    localparam int MMU_PAYLOAD_W = 72;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

    typedef struct packed {
        logic [MMU_ADDR_W-1:0] paddr;
        logic                  uncached;
    } xlat_res_t;

    typedef struct packed {
        logic [MMU_ADDR_W-1:0]    paddr;
        logic [MMU_PAYLOAD_W-1:0] payload;
        logic                     uncached;
    } xlat_entry_t;

    // kseg0/kseg1 strip the top three bits; everything else passes through cached.
    function automatic xlat_res_t seg_translate(input logic [MMU_ADDR_W-1:0] vaddr,
                                                input logic                  k0_uncached);
        xlat_res_t res;
        res.paddr    = vaddr;
        res.uncached = 1'b0;
        case (vaddr[31:29])
            KSEG0: begin
                res.paddr    = {3'b000, vaddr[28:0]};
                res.uncached = k0_uncached;
            end
            KSEG1: begin
                res.paddr    = {3'b000, vaddr[28:0]};
                res.uncached = 1'b1;
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mmu_seg_xlat.sv
// Combinational MIPS32 segment translator, shared by the I-side and D-side queues.
module mmu_seg_xlat
    import mmu_pkg::*;
(
    input  logic [MMU_ADDR_W-1:0] vaddr_i,
    input  logic                  k0_uncached_i,
    output logic [MMU_ADDR_W-1:0] paddr_o,
    output logic                  uncached_o
);

    xlat_res_t res;

    assign res        = seg_translate(vaddr_i, k0_uncached_i);
    assign paddr_o    = res.paddr;
    assign uncached_o = res.uncached;

endmodule

// File: rtl/mmu_xlat_queue.sv
// Request queue between pipeline and cache: translates virtual addresses at
// enqueue and holds up to DEPTH entries. The entry layout is fixed by mmu_pkg.
module mmu_xlat_queue
    import mmu_pkg::*;
#(
    parameter int ADDR_W    = MMU_ADDR_W,
    parameter int PAYLOAD_W = MMU_PAYLOAD_W,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         up_valid,
    input  logic [ADDR_W-1:0]            up_vaddr,
    input  logic [PAYLOAD_W-1:0]         up_payload,
    output logic                         up_ready,
    input  logic                         cfg_k0_uncached,
    input  logic                         flush,
    output logic                         dn_valid,
    output logic [ADDR_W-1:0]            dn_paddr,
    output logic [PAYLOAD_W-1:0]         dn_payload,
    output logic                         dn_uncached,
    input  logic                         dn_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    xlat_entry_t       mem_q [DEPTH];
    xlat_entry_t       mem_d [DEPTH];

    logic [MMU_ADDR_W-1:0] xlat_paddr;
    logic                  xlat_uncached;
    logic                  full, empty, push, pop;

    mmu_seg_xlat u_seg_xlat (
        .vaddr_i       (up_vaddr),
        .k0_uncached_i (cfg_k0_uncached),
        .paddr_o       (xlat_paddr),
        .uncached_o    (xlat_uncached)
    );

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign up_ready = !full && !flush;
    assign dn_valid = !empty;
    assign push     = up_valid && up_ready;
    assign pop      = dn_valid && dn_ready;

    assign dn_paddr    = mem_q[head_q].paddr;
    assign dn_payload  = mem_q[head_q].payload;
    assign dn_uncached = mem_q[head_q].uncached;
    assign count       = count_q;

    // A dequeue in the flush cycle has already been seen by the cache, so
    // flush only has to drop the pointers and count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q].paddr    = xlat_paddr;
                mem_d[tail_q].payload  = up_payload;
                mem_d[tail_q].uncached = xlat_uncached;
                tail_d                 = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
